// File: rtl/prod_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// prod_acc_pkg
// Shared definitions for the product accumulator that sits behind the 16x16
// multiplier stage: default datapath widths and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package prod_acc_pkg;

  // Default widths; the product width must track the multiplier output.
  localparam int DEF_PROD_W = 32;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_LEN_W  = 8;

  // Controller states. Encodings are fixed so the state register can be
  // carried as plain logic [1:0] in legacy-style code.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/prod_accumulator_sat_add.sv
// -----------------------------------------------------------------------------
// sat_add_u
// Combinational unsigned saturating adder: accumulator + zero-extended product.
// Ports:
//   acc     in  ACC_W   current accumulator value
//   prod    in  PROD_W  unsigned product to add
//   sum_sat out ACC_W   acc + prod, clamped to 2^ACC_W-1
//   carry   out 1       the true sum did not fit in ACC_W bits
// ACC_W must be >= PROD_W.
// -----------------------------------------------------------------------------
module sat_add_u
  import prod_acc_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int PROD_W = DEF_PROD_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum_sat,
  output logic              carry
);

  // Returns {carry, clamped sum}. One extra bit of headroom is enough because
  // a single product can never exceed the accumulator range.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  a,
                                             input logic [PROD_W-1:0] b);
    logic [ACC_W:0] full;
    full = {1'b0, a} + (ACC_W+1)'(b);
    if (full[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end
    return full;
  endfunction

  logic [ACC_W:0] res;

  always_comb begin
    res = sat_add(acc, prod);
  end

  assign carry   = res[ACC_W];
  assign sum_sat = res[ACC_W-1:0];

endmodule

// File: rtl/prod_accumulator.sv
// -----------------------------------------------------------------------------
// prod_accumulator
// Sums a programmable-length burst of registered multiplier products into a
// wide saturating accumulator and hands one result per burst downstream over
// a valid/ready handshake.
// Ports:
//   clk          in  1       clock, rising edge
//   rst          in  1       asynchronous active-high reset
//   start        in  1       begin a burst (honoured only when idle)
//   len          in  LEN_W   products in the burst, sampled with start
//   in_valid     in  1       in_product valid this cycle
//   in_product   in  PROD_W  unsigned product from the multiplier
//   in_ready     out 1       a product is accepted this cycle
//   out_valid    out 1       result available
//   out_ready    in  1       downstream takes the result
//   out_sum      out ACC_W   saturated burst sum (holds last delivered value)
//   out_overflow out 1       the sum saturated at some point in the burst
//   busy         out 1       controller not idle
// All outputs come from registers or from the state register alone, so there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_product,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]        state;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [ACC_W-1:0]  sum_q;
  logic              ovf_q;

  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;
  logic              xfer;
  logic              last_xfer;

  sat_add_u #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .acc     (acc),
    .prod    (in_product),
    .sum_sat (add_sum),
    .carry   (add_carry)
  );

  // in_ready is a pure state decode, so the transfer qualifier is the same.
  assign xfer      = (state == ST_ACCUM) && in_valid;
  // len_q is never zero in ACCUM, so len_q-1 cannot wrap here.
  assign last_xfer = xfer && (cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      len_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            if (len == '0) begin
              // Empty burst: publish a zero result immediately.
              state <= ST_DONE;
              sum_q <= '0;
              ovf_q <= 1'b0;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end

        ST_ACCUM: begin
          if (xfer) begin
            acc <= add_sum;
            ovf <= ovf | add_carry;
            cnt <= cnt + LEN_W'(1);
            if (last_xfer) begin
              // The result register is loaded only here, so it keeps the
              // last delivered value through the following IDLE/ACCUM.
              state <= ST_DONE;
              sum_q <= add_sum;
              ovf_q <= ovf | add_carry;
            end
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = (state == ST_ACCUM);
  assign out_valid    = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);
  assign out_sum      = sum_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
module tb_prod_accumulator;

  localparam int PW  = 32;
  localparam int LW  = 8;
  localparam int AW0 = 40;
  localparam int AW1 = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic [PW-1:0] in_product;
  logic          out_ready;

  logic           in_ready0, out_valid0, out_ovf0, busy0;
  logic [AW0-1:0] out_sum0;
  logic           in_ready1, out_valid1, out_ovf1, busy1;
  logic [AW1-1:0] out_sum1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] pv[$];
  bit          vpat[$];

  always #5 clk = ~clk;

  prod_accumulator #(.PROD_W(PW), .ACC_W(AW0), .LEN_W(LW)) dut0 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_product(in_product), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
    .out_overflow(out_ovf0), .busy(busy0)
  );

  prod_accumulator #(.PROD_W(PW), .ACC_W(AW1), .LEN_W(LW)) dut1 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_product(in_product), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
    .out_overflow(out_ovf1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input bit rdy, input bit vld, input bit bsy);
    chk({tag, "/in_ready0"},  in_ready0,  rdy);
    chk({tag, "/out_valid0"}, out_valid0, vld);
    chk({tag, "/busy0"},      busy0,      bsy);
    chk({tag, "/in_ready1"},  in_ready1,  rdy);
    chk({tag, "/out_valid1"}, out_valid1, vld);
    chk({tag, "/busy1"},      busy1,      bsy);
  endtask

  // Reference: the exact sum of the burst, clamped to the result range.
  // Products are non-negative, so saturation happened iff the exact total
  // reaches 2^w.
  function automatic logic [63:0] model_sum(input int w, output bit ovf);
    logic [63:0] tot;
    logic [63:0] lim;
    tot = 64'd0;
    foreach (pv[i]) tot += 64'(pv[i]);
    lim = 64'd1 << w;
    ovf = (tot >= lim);
    return ovf ? (lim - 64'd1) : tot;
  endfunction

  task automatic chk_result(input string tag, input logic [63:0] e0, input bit o0,
                            input logic [63:0] e1, input bit o1);
    chk({tag, "/sum0"}, out_sum0, e0);
    chk({tag, "/ovf0"}, out_ovf0, o0);
    chk({tag, "/sum1"}, out_sum1, e1);
    chk({tag, "/ovf1"}, out_ovf1, o1);
  endtask

  // Runs one burst of length L using the products in pv, starting on a
  // negedge with both DUTs idle. Ends on the negedge after the handshake.
  task automatic burst(input int L, input bit gappy, input int hold,
                       input bit start_with_valid, input bit poke);
    logic [63:0] e0, e1;
    bit          o0, o1;
    int          k, cyc;
    e0 = model_sum(AW0, o0);
    e1 = model_sum(AW1, o1);
    chk_ctrl("pre_idle", 0, 0, 0);
    start      = 1'b1;
    len        = LW'(L);
    in_valid   = start_with_valid;
    in_product = $urandom;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < L) begin
      chk_ctrl("accum", 1, 0, 1);
      if (cyc > 4 * L + 40) begin
        chk("accum_timeout", 64'(k), 64'(L));
        break;
      end
      if (vpat.size() > 0) in_valid = vpat.pop_front();
      else                 in_valid = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_product = in_valid ? pv[k] : $urandom;
      if (in_valid) k++;
      start = poke && ($urandom_range(0, 3) == 0);
      len   = LW'($urandom);
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      chk_ctrl("done", 0, 1, 1);
      chk_result("done", e0, o0, e1, o1);
      out_ready  = (h == hold);
      start      = poke;
      in_valid   = poke;
      len        = LW'($urandom);
      in_product = $urandom;
      @(negedge clk);
    end
    out_ready = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    chk_ctrl("post_idle", 0, 0, 0);
    chk_result("post_hold", e0, o0, e1, o1);
  endtask

  task automatic fill_random(input int n);
    pv.delete();
    for (int i = 0; i < n; i++) pv.push_back($urandom);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    len        = '0;
    in_valid   = 1'b0;
    in_product = '0;
    out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_ctrl("reset", 0, 0, 0);
    chk_result("reset", 64'd0, 1'b0, 64'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Three back-to-back products.
    pv = '{32'd6, 32'd12, 32'd255};
    burst(3, 1'b0, 0, 1'b0, 1'b0);
    chk("t1_sum_const", out_sum0, 64'd273);

    // Gapped valid, result held under backpressure, start pokes ignored.
    pv.delete();
    for (int i = 0; i < 4; i++) pv.push_back(32'hFFFE0001);
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    burst(4, 1'b0, 5, 1'b0, 1'b1);
    chk("t2_sum_const", out_sum0, 64'h3_FFF8_0004);

    // Saturation in the narrow instance, then a clean burst clears it.
    pv.delete();
    for (int i = 0; i < 5; i++) pv.push_back(32'hFFFF_FFFF);
    burst(5, 1'b1, 1, 1'b0, 1'b0);
    chk("t3_sat_const", out_sum1, 64'h3_FFFF_FFFF);
    chk("t3_ovf_const", out_ovf1, 64'd1);
    pv = '{32'd7};
    burst(1, 1'b0, 0, 1'b1, 1'b0);
    chk("t3b_sum_const", out_sum1, 64'd7);
    chk("t3b_ovf_const", out_ovf1, 64'd0);

    // Asynchronous reset part-way through a burst.
    start = 1'b1;
    len   = LW'(4);
    @(negedge clk);
    start      = 1'b0;
    in_valid   = 1'b1;
    in_product = $urandom;
    @(negedge clk);
    in_product = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    chk_ctrl("mid_burst", 1, 0, 1);
    rst = 1'b1;
    #1;
    chk_ctrl("async_rst", 0, 0, 0);
    chk_result("async_rst", 64'd0, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Products offered while idle must not leak into the next burst.
    for (int i = 0; i < 4; i++) begin
      in_valid   = 1'b1;
      in_product = $urandom;
      @(negedge clk);
      chk_ctrl("idle_valid", 0, 0, 0);
    end
    in_valid = 1'b0;
    pv = '{32'd3, 32'd4};
    burst(2, 1'b0, 0, 1'b0, 1'b0);
    chk("t5_sum_const", out_sum0, 64'd7);

    // Empty burst.
    pv.delete();
    burst(0, 1'b0, 2, 1'b0, 1'b1);

    // Random bursts.
    for (int r = 0; r < 12; r++) begin
      int L;
      L = $urandom_range(1, 20);
      fill_random(L);
      burst(L, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Longest burst: wide instance stays exact, narrow one saturates.
    fill_random(255);
    burst(255, 1'b1, 1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
Consumes the registered 32-bit unsigned products of the 16x16 multiplier stage and sums a programmable-length burst of them into a wide accumulator. Emits one result word per burst over a valid/ready handshake to the downstream consumer. Saturates instead of wrapping and reports a sticky overflow flag. Sits directly downstream of the multiplier in the MAC/datapath chain.

Parameters:
PROD_W, 32, width of incoming product (must match multiplier output)
ACC_W, 40, accumulator/result width; must be >= PROD_W
LEN_W, 8, width of burst-length field (max burst 2^LEN_W-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse: begin a new burst (honoured only in IDLE)
len  in  LEN_W  number of products in burst, sampled with start
in_valid  in  1  in_product valid this cycle (caller aligns it with multiplier's 1-cycle latency)
in_product  in  PROD_W  unsigned product from multiplier
in_ready  out  1  block accepts a product this cycle
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_sum  out  ACC_W  saturated unsigned sum of burst
out_overflow  out  1  sum saturated at least once during burst
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any time incl. mid-burst): state=IDLE, acc=0, cnt=0, len_q=0, ovf=0; in_ready=0, out_valid=0, out_sum=0, out_overflow=0, busy=0. Partial burst discarded.
- States: IDLE, ACCUM, DONE. All outputs registered or decoded from state only (no comb path in->out).
- IDLE: in_ready=0. On start: len_q<=len, acc<=0, cnt<=0, ovf<=0; if len==0 -> DONE (out_sum=0, out_overflow=0) else -> ACCUM.
- ACCUM: in_ready=1. Transfer = in_valid & in_ready. On transfer: acc<=sat_add(acc, zero-extended in_product); ovf<=ovf|carry; cnt<=cnt+1. If transfer and cnt==len_q-1 -> DONE. No transfer: hold all.
- DONE: in_ready=0, out_valid=1, out_sum=acc, out_overflow=ovf, all stable until out_ready. On out_valid&out_ready -> IDLE; out_valid deasserts next cycle.
- Latency: out_valid rises the cycle after the last product transfer. len==0: out_valid rises the cycle after start.
- Saturation: if acc+prod >= 2^ACC_W, acc<=2^ACC_W-1 and ovf<=1; further adds keep it saturated. With defaults (255 x (2^32-1) < 2^40) saturation is unreachable; exercised via ACC_W override.
- start while busy: ignored, no side effects. start and in_valid in the same IDLE cycle: product not consumed (in_ready=0).
- in_valid outside ACCUM: ignored. Minimum inter-burst gap: one IDLE cycle after result handshake.
- out_sum/out_overflow in IDLE/ACCUM: hold last delivered value (0 after reset).

Decomposition:
- Package prod_acc_pkg: state enum (IDLE, ACCUM, DONE), default width constants PROD_W/ACC_W/LEN_W.
- Sub-module sat_add_u (combinational, parameterised width): ACC_W + PROD_W unsigned add -> {sum_sat, carry}. FSM, counter, handshake stay in prod_accumulator.

Test Plan:
- Reset then start, len=3, products 6, 12, 255 on consecutive cycles -> out_valid one cycle after 3rd transfer, out_sum=273, out_overflow=0, busy high from start until handshake.
- len=4, in_valid gapped (valid, idle, idle, valid, valid, idle, valid) with products 0xFFFE0001 each -> out_sum=0x3FFF80004, held with out_ready=0 for 5 cycles then accepted; out_valid drops next cycle.
- ACC_W=34 override, len=5, each product 0xFFFFFFFF -> out_sum=0x3FFFFFFFF, out_overflow=1; next burst len=1 product 7 -> out_sum=7, out_overflow=0.
- start with len=0 -> out_valid the next cycle, out_sum=0, in_ready never asserted.
- Mid-burst (2 of 4 accepted) assert rst for 1 cycle -> all outputs 0 immediately; new burst len=2 products 3,4 -> out_sum=7.
- start pulsed during ACCUM and DONE -> ignored, current result unaffected; in_valid in IDLE -> no transfer, acc unchanged.
